// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the display timing generator.
//   display_mode_t      : pattern select encoding (external/gradient/bars/solid)
//   BAR_*               : the eight colour-bar colours, left to right
//   align_t             : bundle of counter-level attributes carried through the
//                         latency-matching delay line
//   DEFAULT_COORD_WIDTH : default signed coordinate width
//   bar_colour()        : bar index -> 24-bit colour
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DEFAULT_COORD_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_EXTERNAL = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_BARS     = 2'd2,
        MODE_SOLID    = 2'd3
    } display_mode_t;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Everything the output stage needs about a counter position, so that it
    // can be delayed to meet the pixel returned by the upstream source.
    typedef struct packed {
        logic          en;
        logic          hs;
        logic          vs;
        display_mode_t mode;
        logic [7:0]    x_lsb;
        logic [7:0]    y_lsb;
        logic [2:0]    bar;
    } align_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// -----------------------------------------------------------------------------
// display_timing_gen_if
// Pixel-fetch bus between the timing generator and the upstream pixel source.
//   pixel_req  : request strobe for pixel_x/pixel_y
//   pixel_x/y  : requested coordinate
//   pixel_rgb  : returned pixel, valid a fixed latency after its request
// Modports: master (timing generator), slave (pixel source).
// -----------------------------------------------------------------------------
interface display_timing_gen_if
    import display_pkg::*;
#(
    parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH
);
    logic                   pixel_req;
    logic [COORD_WIDTH-1:0] pixel_x;
    logic [COORD_WIDTH-1:0] pixel_y;
    logic [23:0]            pixel_rgb;

    modport master (output pixel_req, output pixel_x, output pixel_y, input pixel_rgb);
    modport slave  (input pixel_req, input pixel_x, input pixel_y, output pixel_rgb);
endinterface

// File: rtl/display_delay_line.sv
// -----------------------------------------------------------------------------
// display_delay_line
// WIDTH-bit shift register of DEPTH stages with synchronous active-low clear.
// DEPTH = 0 is a plain passthrough.
//   clk_i   : clock
//   rst_n_i : synchronous clear, active low
//   d_i     : input word
//   q_o     : word delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module display_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    if (DEPTH == 0) begin : g_pass
        logic unused_s;
        assign unused_s = clk_i ^ rst_n_i;
        assign q_o      = d_i;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift chain; cleared as a whole so nothing in flight survives reset.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
// Parametrised raster timing generator. Walks signed x/y counters over the
// whole frame, requests active pixels from an upstream source of fixed
// latency, and emits hsync/vsync/enable/rgb aligned with the returned data.
// Every video_* output lags its counter state by PIXEL_LATENCY+2 clocks.
//   pixel_clock  : clock
//   reset_n      : synchronous reset, active low
//   mode         : pattern select, latched at each frame boundary
//   solid_rgb    : colour for solid mode
//   pix          : pixel-fetch bus (master side)
//   frame_count  : completed frames (undelayed)
//   video_rgb/enable/vsync/hsync : aligned video output
// Optional: define DISPLAY_TIMING_SCANLINE_EN to halve every channel on odd
// active rows.
// -----------------------------------------------------------------------------
module display_timing_gen
    import display_pkg::*;
#(
    parameter int COORD_WIDTH   = DEFAULT_COORD_WIDTH,
    parameter int H_ACTIVE      = 400,
    parameter int H_TOTAL       = 480,
    parameter int H_BACK_PORCH  = 10,
    parameter int V_ACTIVE      = 360,
    parameter int V_TOTAL       = 512,
    parameter int V_BACK_PORCH  = 10,
    parameter int HSYNC_DELAY   = 3,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic                        pixel_clock,
    input  logic                        reset_n,
    input  logic [1:0]                  mode,
    input  logic [23:0]                 solid_rgb,
    display_timing_gen_if.master        pix,
    output logic [15:0]                 frame_count,
    output logic [23:0]                 video_rgb,
    output logic                        video_enable,
    output logic                        video_vsync,
    output logic                        video_hsync
);
    if (H_ACTIVE > H_TOTAL - H_BACK_PORCH) begin : g_chk_h
        $fatal(1, "H_ACTIVE does not fit after the horizontal back porch");
    end
    if (V_ACTIVE > V_TOTAL - V_BACK_PORCH) begin : g_chk_v
        $fatal(1, "V_ACTIVE does not fit after the vertical back porch");
    end
    if (HSYNC_DELAY >= H_BACK_PORCH) begin : g_chk_hs
        $fatal(1, "HSYNC_DELAY must be smaller than H_BACK_PORCH");
    end
    if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 15) begin : g_chk_lat
        $fatal(1, "PIXEL_LATENCY must be within 0..15");
    end

    typedef logic signed [COORD_WIDTH-1:0] coord_t;

    localparam coord_t X_START = COORD_WIDTH'(-H_BACK_PORCH);
    localparam coord_t X_END   = COORD_WIDTH'(H_TOTAL - H_BACK_PORCH - 1);
    localparam coord_t Y_START = COORD_WIDTH'(-V_BACK_PORCH);
    localparam coord_t Y_END   = COORD_WIDTH'(V_TOTAL - V_BACK_PORCH - 1);
    localparam coord_t X_HSYNC = COORD_WIDTH'(HSYNC_DELAY - H_BACK_PORCH);
    localparam coord_t X_PRE   = COORD_WIDTH'(-1);
    localparam coord_t X_ACT   = COORD_WIDTH'(H_ACTIVE);
    localparam coord_t Y_ACT   = COORD_WIDTH'(V_ACTIVE);
    localparam coord_t C_ZERO  = COORD_WIDTH'(0);
    localparam coord_t C_ONE   = COORD_WIDTH'(1);
    // Remainder columns stay in the last bar because the index saturates at 7.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [COORD_WIDTH-1:0] BAR_LAST = COORD_WIDTH'(BAR_W - 1);
    localparam logic [COORD_WIDTH-1:0] COL_ONE  = COORD_WIDTH'(1);

    coord_t                 x_q, x_d, y_q, y_d;
    logic                   wrap_s, active_s, hsync_s;
    logic                   vsync_q;
    display_mode_t          active_mode_q;
    logic [15:0]            frame_count_q;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [COORD_WIDTH-1:0] bar_col_q, bar_col_d;
    logic                   req_q;
    coord_t                 px_q, py_q;
    align_t                 align_in_s, align_out_s;
    logic [23:0]            pat_rgb_s, rgb_d;
    logic [23:0]            video_rgb_q;
    logic                   video_enable_q, video_vsync_q, video_hsync_q;

    // Next raster position and the end-of-frame wrap event.
    always_comb begin
        x_d    = x_q + C_ONE;
        y_d    = y_q;
        wrap_s = 1'b0;
        if (x_q == X_END) begin
            x_d = X_START;
            if (y_q == Y_END) begin
                y_d    = Y_START;
                wrap_s = 1'b1;
            end else begin
                y_d = y_q + C_ONE;
            end
        end else begin
            y_d = y_q;
        end
    end

    // Bar index follows x incrementally: restarts just before x=0, then
    // advances every BAR_W columns and sticks at the last bar.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_col_d = bar_col_q;
        if (x_q == X_PRE) begin
            bar_idx_d = 3'd0;
            bar_col_d = '0;
        end else if (bar_idx_q == 3'd7) begin
            bar_col_d = bar_col_q;
        end else if (bar_col_q == BAR_LAST) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_col_d = '0;
        end else begin
            bar_col_d = bar_col_q + COL_ONE;
        end
    end

    assign active_s = (x_q >= C_ZERO) && (x_q < X_ACT) && (y_q >= C_ZERO) && (y_q < Y_ACT);
    // vsync_q marks the first counter position of a new frame; hsync yields to it.
    assign hsync_s  = (x_q == X_HSYNC) && !vsync_q;

    // Raster counters, frame event, mode latch and frame counter.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            x_q           <= X_START;
            y_q           <= Y_START;
            vsync_q       <= 1'b0;
            active_mode_q <= MODE_EXTERNAL;
            frame_count_q <= 16'd0;
            bar_idx_q     <= 3'd0;
            bar_col_q     <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vsync_q   <= wrap_s;
            bar_idx_q <= bar_idx_d;
            bar_col_q <= bar_col_d;
            if (wrap_s) begin
                active_mode_q <= display_mode_t'(mode);
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Request stage: strobe active points, hold coordinates otherwise.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            req_q <= 1'b0;
            px_q  <= C_ZERO;
            py_q  <= C_ZERO;
        end else begin
            req_q <= active_s;
            if (active_s) begin
                px_q <= x_q;
                py_q <= y_q;
            end
        end
    end

    assign pix.pixel_req = req_q;
    assign pix.pixel_x   = px_q;
    assign pix.pixel_y   = py_q;

    assign align_in_s = '{en: active_s, hs: hsync_s, vs: vsync_q, mode: active_mode_q,
                          x_lsb: x_q[7:0], y_lsb: y_q[7:0], bar: bar_idx_q};

    display_delay_line #(
        .WIDTH ($bits(align_t)),
        .DEPTH (PIXEL_LATENCY + 1)
    ) u_align (
        .clk_i   (pixel_clock),
        .rst_n_i (reset_n),
        .d_i     (align_in_s),
        .q_o     (align_out_s)
    );

    // Pattern pixel for the aligned position, blanked outside the active area.
    always_comb begin
        case (align_out_s.mode)
            MODE_EXTERNAL: pat_rgb_s = pix.pixel_rgb;
            MODE_GRADIENT: pat_rgb_s = {align_out_s.x_lsb, align_out_s.y_lsb, 8'd64};
            MODE_BARS:     pat_rgb_s = bar_colour(align_out_s.bar);
            MODE_SOLID:    pat_rgb_s = solid_rgb;
            default:       pat_rgb_s = 24'h000000;
        endcase
        if (!align_out_s.en) begin
            rgb_d = 24'h000000;
`ifdef DISPLAY_TIMING_SCANLINE_EN
        end else if (align_out_s.y_lsb[0]) begin
            rgb_d = {1'b0, pat_rgb_s[23:17], 1'b0, pat_rgb_s[15:9], 1'b0, pat_rgb_s[7:1]};
`endif
        end else begin
            rgb_d = pat_rgb_s;
        end
    end

    // Output register.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            video_rgb_q    <= 24'h000000;
            video_enable_q <= 1'b0;
            video_vsync_q  <= 1'b0;
            video_hsync_q  <= 1'b0;
        end else begin
            video_rgb_q    <= rgb_d;
            video_enable_q <= align_out_s.en;
            video_vsync_q  <= align_out_s.vs;
            video_hsync_q  <= align_out_s.hs;
        end
    end

    assign frame_count  = frame_count_q;
    assign video_rgb    = video_rgb_q;
    assign video_enable = video_enable_q;
    assign video_vsync  = video_vsync_q;
    assign video_hsync  = video_hsync_q;
endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Parametrised successor to the fixed 400x360 display generator. Produces hsync, vsync and enable timing for any resolution and porch set chosen at elaboration.
- Issues pixel-coordinate requests to an upstream pixel source (framebuffer or tile fetch) that has a fixed read latency. Sync and enable are delayed to stay aligned with the returned pixel data.
- Built-in pattern modes: external, gradient, colour bars, solid. Mode changes take effect only at frame boundaries.
- Sits between the core pixel source and the scaler video output.

Parameters:
- COORD_WIDTH, 16, signed coordinate width.
- H_ACTIVE, 400, visible pixels per line.
- H_TOTAL, 480, clocks per line.
- H_BACK_PORCH, 10, clocks from line start to x=0.
- V_ACTIVE, 360, visible lines.
- V_TOTAL, 512, lines per frame.
- V_BACK_PORCH, 10, lines from frame start to y=0.
- HSYNC_DELAY, 3, clocks after line start at which hsync pulses.
- PIXEL_LATENCY, 2, cycles from pixel_req to valid pixel_rgb (0..15).

Ports:
- pixel_clock  in  1  sole clock.
- reset_n  in  1  synchronous active-low reset.
- mode  in  2  pattern select: 0 external, 1 gradient, 2 colour bars, 3 solid.
- solid_rgb  in  24  colour used in mode 3.
- pixel_rgb  in  24  upstream pixel, valid PIXEL_LATENCY cycles after its request.
- pixel_req  out  1  request strobe for pixel_x/pixel_y.
- pixel_x  out  COORD_WIDTH  requested column, 0..H_ACTIVE-1.
- pixel_y  out  COORD_WIDTH  requested row, 0..V_ACTIVE-1.
- frame_count  out  16  completed frames, wraps at 16'hFFFF->0.
- video_rgb  out  24  output pixel.
- video_enable  out  1  active-region flag.
- video_vsync  out  1  one-cycle frame pulse.
- video_hsync  out  1  one-cycle line pulse.

Behaviour:
- Counters: x runs -H_BACK_PORCH .. H_TOTAL-H_BACK_PORCH-1; y runs -V_BACK_PORCH .. V_TOTAL-V_BACK_PORCH-1. y increments when x wraps; y wraps at its end.
- Reset (reset_n low at a clock edge): x=-H_BACK_PORCH, y=-V_BACK_PORCH. All outputs and all delay-line stages go to 0, and frame_count=0. Reset mid-frame discards in-flight pixels; no partial syncs are emitted after release.
- Active region: 0<=x<H_ACTIVE and 0<=y<V_ACTIVE.
- Request stage (registered): pixel_req=1 with pixel_x=x, pixel_y=y one cycle after the counter sits on an active point; otherwise pixel_req=0 and the coordinates hold their last values.
- Sync generation, at counter level:
  - vsync is raised on the counter wrap from (x_end, y_end) to start.
  - hsync is raised when x == -H_BACK_PORCH+HSYNC_DELAY.
  - hsync never coincides with a vsync cycle.
- Alignment: enable, hsync, vsync, mode tag and pattern inputs pass through a delay line of PIXEL_LATENCY+1 stages, followed by one output register. Every video_* output therefore lags its counter state by PIXEL_LATENCY+2 cycles, and pixel_rgb is sampled on the aligned cycle.
- Outside the active region, video_rgb=0 and video_enable=0.
- Active output by mode:
  - mode 0: pixel_rgb.
  - mode 1: {x[7:0], y[7:0], 8'd64}.
  - mode 2: 8 equal bars of width H_ACTIVE/8 (integer; the remainder columns take the last bar). Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. The bar index is tracked with an incremental counter; no divider.
  - mode 3: solid_rgb.
- Mode latching: mode is sampled into active_mode on the vsync counter event; the reset value is 0. A mode change mid-frame is not visible until the next frame.
- frame_count increments on the same counter event and is exposed undelayed.
- Elaboration checks (fatal assertion on failure): H_ACTIVE<=H_TOTAL-H_BACK_PORCH, V_ACTIVE<=V_TOTAL-V_BACK_PORCH, and HSYNC_DELAY<H_BACK_PORCH.

Optional Feature:
- Macro: DISPLAY_TIMING_SCANLINE_EN.
- Defined: on odd active rows (y[0]==1), every channel of the final video_rgb is right-shifted by 1, in all modes. The shift is applied at the output register, so latency is unchanged.
- Undefined: no shifting logic exists and output is the unmodified mode pixel.

Decomposition:
- Shared package display_pkg holds:
  - the display_mode_t enum (MODE_EXTERNAL, MODE_GRADIENT, MODE_BARS, MODE_SOLID);
  - the eight 24-bit bar colour constants;
  - the default COORD_WIDTH.
- One sub-module, display_delay_line: parametrised width/depth shift register with synchronous active-low clear, depth 0 meaning passthrough. It carries the enable, sync, coordinate-LSB and bar-index bits.

Test Plan (H_ACTIVE=16, H_TOTAL=20, H_BACK_PORCH=2, V_ACTIVE=4, V_TOTAL=6, V_BACK_PORCH=1, HSYNC_DELAY=1, PIXEL_LATENCY=2):
- Free run 3 frames -> vsync period exactly 120 cycles, hsync period 20, 64 video_enable cycles per frame in 4 runs of 16, frame_count steps 0->1->2->3.
- Mode 0 with pixel_rgb = {8'h0, pixel_y[7:0], pixel_x[7:0]} driven through a 2-cycle model -> video_rgb equals {0,y,x} on every enabled cycle, with the first enabled pixel 000000 and the last 00030F.
- Mode 2 -> each line shows bar colours in pairs: pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000.
- Mode switched 1->3 (solid_rgb=123456) mid-frame -> the rest of the current frame stays gradient; the next frame is all 123456.
- reset_n low for 1 cycle mid-active-line -> all outputs 0 the next cycle, and the next vsync arrives 120+4 cycles after release with no stray enable before it.
- DISPLAY_TIMING_SCANLINE_EN defined, mode 3 with solid_rgb=FEFEFE -> rows 0,2 show FEFEFE and rows 1,3 show 7F7F7F.
